instruction_fetch: RTL and testbench

- Initiator side of the instruction-memory read interface. Holds the PC, drives read_address, and captures inst from the synchronous-read Instruction_Memory.
- Presents an IF/ID register set (instruction, PC, PC+4, valid) to decode.
- Supports decode stalls without losing in-flight data, and branch/jump redirects that flush anything in flight.

---
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, instruction-memory request, skid buffer and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / bubble_cnt counters.
module instruction_fetch #(
   parameter int                  ADDR_W   = 32,
   parameter int                  DATA_W   = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] read_address,
   output logic              read_en,
   input  logic [DATA_W-1:0] inst,
   output logic [DATA_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus4,
   output logic              if_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic [ADDR_W-1:0] pc_q;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_pc;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_inst;
   logic [ADDR_W-1:0] skid_pc;
   logic              load;
   logic              bubble;
   logic              unused_ok;

   assign read_address = pc_q;
   assign read_en      = rst & ~stall & ~redirect;
   assign load         = ~redirect & ~stall & (skid_valid | pend_valid);
   assign bubble       = ~stall & ~load;
   assign unused_ok    = ^{redirect_pc[1:0], bubble};

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_pc     <= '0;
         skid_valid  <= 1'b0;
         skid_inst   <= '0;
         skid_pc     <= '0;
         if_valid    <= 1'b0;
         if_inst     <= '0;
         if_pc       <= '0;
         if_pc_plus4 <= PC_STEP;
      end else if (redirect) begin
         pc_q       <= {redirect_pc[ADDR_W-1:2], 2'b00};
         pend_valid <= 1'b0;
         skid_valid <= 1'b0;
         if_valid   <= 1'b0;
      end else if (stall) begin
         // park the in-flight word; the memory will not hold it for us
         pend_valid <= 1'b0;
         if (pend_valid) begin
            skid_inst  <= inst;
            skid_pc    <= pend_pc;
            skid_valid <= 1'b1;
         end
      end else begin
         pend_pc    <= pc_q;
         pend_valid <= 1'b1;
         pc_q       <= pc_q + PC_STEP;
         if (skid_valid) begin
            if_inst     <= skid_inst;
            if_pc       <= skid_pc;
            if_pc_plus4 <= skid_pc + PC_STEP;
            if_valid    <= 1'b1;
            skid_valid  <= 1'b0;
         end else if (pend_valid) begin
            if_inst     <= inst;
            if_pc       <= pend_pc;
            if_pc_plus4 <= pend_pc + PC_STEP;
            if_valid    <= 1'b1;
         end else begin
            if_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (load)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (bubble)
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stream model vs. IF/ID outputs.
// A second instance checks RESET_PC near the top of the address space.
module tb_instruction_fetch;

   typedef struct {
      logic        v;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] p4;
      logic [31:0] addr;
      logic        ren;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] read_address, inst, if_inst, if_pc, if_pc_plus4;
   logic        read_en, if_valid;

   logic        rst2, zero;
   logic [31:0] zero32;
   logic [31:0] ra2, inst2, ins2, pc2, p42;
   logic        ren2, v2;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt, bubble_cnt, fetch_cnt2, bubble_cnt2;
`endif

   int          checks = 0;
   int          failures = 0;
   exp_t        q[$];
   exp_t        held;
   logic [31:0] start;
   int          u;
   int          nfetch;
   bit          wrap_done = 0;

   always #5 clk = ~clk;

   instruction_fetch dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .read_address(read_address),
      .read_en(read_en), .inst(inst), .if_inst(if_inst), .if_pc(if_pc),
      .if_pc_plus4(if_pc_plus4), .if_valid(if_valid)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst2), .stall(zero), .redirect(zero),
      .redirect_pc(zero32), .read_address(ra2),
      .read_en(ren2), .inst(inst2), .if_inst(ins2), .if_pc(pc2),
      .if_pc_plus4(p42), .if_valid(v2)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt(fetch_cnt2), .bubble_cnt(bubble_cnt2)
`endif
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   always @(posedge clk) begin
      inst  <= word(read_address);
      inst2 <= word(ra2);
   end

   function automatic void chk(input string n, input logic [31:0] a,
                               input logic [31:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", n, a, x);
      end
   endfunction

   // model: a fetch stream from `start`; after u unstalled edges the
   // (u-1)th word of the stream is on IF/ID and word u is being fetched
   task automatic step(input logic r, input logic s, input logic d,
                       input logic [31:0] dpc, input string tag);
      exp_t e;
      @(negedge clk);
      rst = r; stall = s; redirect = d; redirect_pc = dpc;
      e = held;
      e.tag = tag;
      e.ren = r & ~s & ~d;
      if (!r) begin
         e.v = 0; e.ins = 0; e.pc = 0; e.p4 = 32'd4;
         start = 32'h0; u = 0; nfetch = 0;
      end else if (d) begin
         e.v = 0;
         start = {dpc[31:2], 2'b00}; u = 0;
      end else if (!s) begin
         u++;
         if (u >= 2) begin
            e.v   = 1;
            e.pc  = start + 32'(u - 2) * 32'd4;
            e.ins = word(e.pc);
            e.p4  = e.pc + 32'd4;
            nfetch++;
         end else begin
            e.v = 0;
         end
      end
      e.addr = start + 32'(u) * 32'd4;
      held = e;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "_valid"}, 32'(if_valid), 32'(e.v));
            chk({e.tag, "_addr"}, read_address, e.addr);
            chk({e.tag, "_ren"}, 32'(read_en), 32'(e.ren));
            if (e.v || !rst) begin
               chk({e.tag, "_pc"}, if_pc, e.pc);
               chk({e.tag, "_inst"}, if_inst, e.ins);
               chk({e.tag, "_pc4"}, if_pc_plus4, e.p4);
            end
         end
      end
   end

   initial begin : wrap_test
      zero = 0; zero32 = 0; rst2 = 0;
      repeat (2) @(negedge clk);
      rst2 = 1;
      @(posedge clk); #2;
      chk("wrap_first_valid", 32'(v2), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #2;
         chk("wrap_valid", 32'(v2), 32'd1);
         chk("wrap_pc", pc2, 32'hFFFF_FFF8 + 32'(k) * 32'd4);
         chk("wrap_pc4", p42, 32'hFFFF_FFFC + 32'(k) * 32'd4);
         chk("wrap_inst", ins2, word(32'hFFFF_FFF8 + 32'(k) * 32'd4));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("wrap_fetch_cnt", fetch_cnt2, 32'd3);
`endif
      wrap_done = 1;
   end

   initial begin : stim
      logic r, s, d;
      logic [31:0] t;
      rst = 0; stall = 0; redirect = 0; redirect_pc = 0;
      start = 0; u = 0; nfetch = 0;
      repeat (2) step(0, 0, 0, 0, "reset");
      repeat (4) step(1, 0, 0, 0, "run");
      repeat (3) step(1, 1, 0, 0, "stall8");
      repeat (2) step(1, 0, 0, 0, "resume");
      step(1, 0, 1, 32'h0000_0043, "redir");
      repeat (5) step(1, 0, 0, 0, "target");
      step(1, 1, 0, 0, "skidfill");
      step(1, 1, 1, 32'h0000_0100, "redir_stall");
      repeat (3) step(1, 0, 0, 0, "after_rs");
      step(1, 1, 0, 0, "skidfill2");
      step(0, 1, 0, 0, "midreset");
      repeat (4) step(1, 0, 0, 0, "restart");
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 39) != 0);
         s = ($urandom_range(0, 2) == 0);
         d = ($urandom_range(0, 9) == 0);
         t = $urandom();
         if ($urandom_range(0, 3) == 0)
            t = 32'hFFFF_FFF0 | (t & 32'hF);
         step(r, s, d, t, "rand");
      end
      repeat (20) step(1, 0, 0, 0, "drain");
      @(posedge clk); #4;
      chk("sb_empty", 32'(q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, 32'(nfetch));
`endif
      chk("wrap_done", 32'(wrap_done), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
